// File: rtl/gpio_in_cond_pkg.sv
// Shared constants for the GPIO input conditioner.
package gpio_in_cond_pkg;
  localparam int GPIO_IN_WIDTH        = 13;
  localparam int DB_LIMIT_100MHZ_10MS = 1000000;
  localparam int DB_CNT_W             = 20;
  localparam int SYNC_STAGES_DEF      = 2;
endpackage

// File: rtl/gpio_in_cond_if.sv
// Pad-side inputs, conditioned outputs and event/irq controls of gpio_in_cond.
interface gpio_in_cond_if
  import gpio_in_cond_pkg::*;
#(
  parameter int WIDTH = GPIO_IN_WIDTH
);
  logic [WIDTH-1:0] pin_in;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] evt_clr;
  logic [WIDTH-1:0] evt_flag;
  logic [WIDTH-1:0] irq_mask;
  logic             irq;

  modport master (
    output pin_in, evt_clr, irq_mask,
    input  level, rise, fall, evt_flag, irq
  );

  modport slave (
    input  pin_in, evt_clr, irq_mask,
    output level, rise, fall, evt_flag, irq
  );
endinterface

// File: rtl/gpio_in_cond_debounce_bit.sv
// One GPIO bit: synchroniser chain, stable-run counter, debounced level and
// registered rise/fall pulses coincident with the level change.
module gpio_in_cond_debounce_bit
  import gpio_in_cond_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CNT_W_P  = DB_CNT_W,
  parameter int DB_LIMIT    = DB_LIMIT_100MHZ_10MS
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  localparam logic [DB_CNT_W_P-1:0] CNT_TC = DB_CNT_W_P'(DB_LIMIT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DB_CNT_W_P-1:0]  cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pin_i};
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TC) begin
      // Mismatch has now been seen DB_LIMIT consecutive edges: accept it.
      level_d = sync_s;
      cnt_d   = '0;
      rise_d  = sync_s;
      fall_d  = ~sync_s;
    end else begin
      cnt_d = cnt_q + DB_CNT_W_P'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: per-bit debounce, sticky edge flags and a masked,
// registered interrupt line feeding the localbus GPIO input port.
module gpio_in_cond
  import gpio_in_cond_pkg::*;
#(
  parameter int WIDTH       = GPIO_IN_WIDTH,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CNT_W_P  = DB_CNT_W,
  parameter int DB_LIMIT    = DB_LIMIT_100MHZ_10MS
) (
  input  logic           clk,
  input  logic           rst,
  gpio_in_cond_if.slave  bus
);
  logic [WIDTH-1:0] level_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;
  logic [WIDTH-1:0] flag_q, flag_d;
  logic             irq_q, irq_d;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    gpio_in_cond_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CNT_W_P  (DB_CNT_W_P),
      .DB_LIMIT    (DB_LIMIT)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .pin_i   (bus.pin_in[g]),
      .level_o (level_w[g]),
      .rise_o  (rise_w[g]),
      .fall_o  (fall_w[g])
    );
  end

  // A new edge in the same cycle as a clear keeps the flag set.
  always_comb begin
    flag_d = (flag_q & ~bus.evt_clr) | rise_w | fall_w;
    irq_d  = |(flag_q & bus.irq_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      irq_q  <= irq_d;
    end
  end

  assign bus.level    = level_w;
  assign bus.rise     = rise_w;
  assign bus.fall     = fall_w;
  assign bus.evt_flag = flag_q;
  assign bus.irq      = irq_q;
endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed bench for gpio_in_cond with DB_LIMIT=4, SYNC_STAGES=2, WIDTH=13.
module tb_gpio_in_cond;
  localparam int W = 13;

  typedef struct {
    logic [W-1:0] pin;
    logic [W-1:0] clr;
    logic [W-1:0] mask;
    logic [W-1:0] lvl;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] flag;
    logic         irq;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  gpio_in_cond_if #(.WIDTH(W)) bus_if ();

  gpio_in_cond #(
    .WIDTH       (W),
    .SYNC_STAGES (2),
    .DB_CNT_W_P  (20),
    .DB_LIMIT    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [W-1:0] pin, input logic [W-1:0] clr, input logic [W-1:0] mask,
                     input logic [W-1:0] lvl, input logic [W-1:0] rise, input logic [W-1:0] fall,
                     input logic [W-1:0] flag, input logic irq);
    vec_t v;
    v.pin = pin; v.clr = clr; v.mask = mask; v.lvl = lvl;
    v.rise = rise; v.fall = fall; v.flag = flag; v.irq = irq;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [W-1:0] pin, input logic [W-1:0] clr, input logic [W-1:0] mask,
                      input logic r);
    @(negedge clk);
    bus_if.pin_in   = pin;
    bus_if.evt_clr  = clr;
    bus_if.irq_mask = mask;
    rst             = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_if.pin_in   = '0;
    bus_if.evt_clr  = '0;
    bus_if.irq_mask = '0;

    // Rows are one clock each; expectations are the outputs after that edge.
    for (int i = 0; i < 5; i++) add(13'h0001, 0, 0, 0, 0, 0, 0, 0);
    add(13'h0001, 0, 0, 13'h0001, 13'h0001, 0, 0, 0);
    for (int i = 0; i < 2; i++) add(13'h0001, 0, 0, 13'h0001, 0, 0, 13'h0001, 0);
    for (int i = 0; i < 3; i++) add(13'h0009, 0, 0, 13'h0001, 0, 0, 13'h0001, 0);
    for (int i = 0; i < 4; i++) add(13'h0001, 0, 0, 13'h0001, 0, 0, 13'h0001, 0);
    for (int i = 0; i < 5; i++) add(13'h0000, 0, 0, 13'h0001, 0, 0, 13'h0001, 0);
    add(13'h0000, 0, 0, 0, 0, 13'h0001, 13'h0001, 0);
    add(13'h0000, 13'h0001, 0, 0, 0, 0, 13'h0001, 0);
    add(13'h0000, 13'h0000, 0, 0, 0, 0, 13'h0001, 0);
    add(13'h0000, 13'h0001, 0, 0, 0, 0, 13'h0000, 0);
    add(13'h0000, 13'h0002, 0, 0, 0, 0, 13'h0000, 0);
    for (int i = 0; i < 5; i++) add(13'h0010, 0, 13'h0020, 0, 0, 0, 0, 0);
    add(13'h0010, 0, 13'h0020, 13'h0010, 13'h0010, 0, 0, 0);
    add(13'h0010, 0, 13'h0020, 13'h0010, 0, 0, 13'h0010, 0);
    for (int i = 0; i < 5; i++) add(13'h0030, 0, 13'h0020, 13'h0010, 0, 0, 13'h0010, 0);
    add(13'h0030, 0, 13'h0020, 13'h0030, 13'h0020, 0, 13'h0010, 0);
    add(13'h0030, 0, 13'h0020, 13'h0030, 0, 0, 13'h0030, 0);
    add(13'h0030, 0, 13'h0020, 13'h0030, 0, 0, 13'h0030, 1);
    add(13'h0030, 13'h0020, 13'h0020, 13'h0030, 0, 0, 13'h0010, 1);
    add(13'h0030, 0, 13'h0020, 13'h0030, 0, 0, 13'h0010, 0);
    add(13'h0030, 0, 13'h0010, 13'h0030, 0, 0, 13'h0010, 1);
    add(13'h0030, 0, 13'h0000, 13'h0030, 0, 0, 13'h0010, 0);

    // Reset with all pins high: every output stays 0.
    for (int c = 0; c < 3; c++) begin
      step(13'h1FFF, 0, 0, 1'b1);
      chk($sformatf("rst%0d level", c), bus_if.level, 0);
      chk($sformatf("rst%0d rise", c), bus_if.rise, 0);
      chk($sformatf("rst%0d fall", c), bus_if.fall, 0);
      chk($sformatf("rst%0d flag", c), bus_if.evt_flag, 0);
      chk($sformatf("rst%0d irq", c), {12'b0, bus_if.irq}, 0);
    end

    foreach (vecs[i]) begin
      step(vecs[i].pin, vecs[i].clr, vecs[i].mask, 1'b0);
      chk($sformatf("row%0d level", i), bus_if.level, vecs[i].lvl);
      chk($sformatf("row%0d rise", i), bus_if.rise, vecs[i].rise);
      chk($sformatf("row%0d fall", i), bus_if.fall, vecs[i].fall);
      chk($sformatf("row%0d flag", i), bus_if.evt_flag, vecs[i].flag);
      chk($sformatf("row%0d irq", i), {12'b0, bus_if.irq}, {12'b0, vecs[i].irq});
    end

    // Reset mid-count on pin 7 discards progress; full latency restarts.
    step(13'h0000, 0, 0, 1'b1);
    for (int c = 0; c < 3; c++) step(13'h0080, 0, 0, 1'b0);
    step(13'h0080, 0, 0, 1'b1);
    chk("midrst level", bus_if.level, 0);
    for (int k = 1; k <= 7; k++) begin
      step(13'h0080, 0, 0, 1'b0);
      chk($sformatf("p7 k%0d level", k), bus_if.level, (k >= 6) ? 13'h0080 : 13'h0000);
      chk($sformatf("p7 k%0d rise", k), bus_if.rise, (k == 6) ? 13'h0080 : 13'h0000);
      if (k == 7) chk("p7 flag", bus_if.evt_flag, 13'h0080);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
